// File: rtl/rv_sched_pkg.sv
// Shared scheduler types and defaults used by the divide scheduler and
// reusable by the other commit-window schedulers.
package rv_sched_pkg;

    localparam int NCOMMIT_DEF  = 32;
    localparam int LNCOMMIT_DEF = 5;
    localparam int DLAT_DEF     = 34;
    localparam int CNTW         = $clog2(DLAT_DEF + 1);

    typedef logic [LNCOMMIT_DEF-1:0] commit_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_sched_oldest_pick.sv
// Oldest-first selector over a circular commit window: rotate the mask so the
// head sits at bit 0, priority-encode the lowest set bit, then un-rotate.
module oldest_pick #(
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = 5
) (
    input  logic [NCOMMIT-1:0]  mask,
    input  logic [LNCOMMIT-1:0] head,
    output logic                any,
    output logic [LNCOMMIT-1:0] idx
);

    logic [2*NCOMMIT-1:0] w_dbl;
    logic [NCOMMIT-1:0]   w_rot;
    logic [LNCOMMIT-1:0]  w_p;

    assign w_dbl = {mask, mask};
    assign w_rot = w_dbl[head +: NCOMMIT];

    // Scan downward so the lowest set bit (nearest the head) wins.
    always_comb begin
        w_p = '0;
        for (int i = NCOMMIT - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_p = LNCOMMIT'(i);
            end
        end
    end

    assign any = |mask;
    assign idx = w_p + head;

endmodule

// File: rtl/div_sched.sv
// Issue scheduler for the single shared, non-pipelined divide/remainder unit:
// picks the oldest ready entry, tracks the fixed latency, reports completion.
module div_sched
    import rv_sched_pkg::*;
#(
    parameter int NCOMMIT  = NCOMMIT_DEF,
    parameter int LNCOMMIT = LNCOMMIT_DEF,
    parameter int DLAT     = DLAT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LNCOMMIT-1:0] commit_head,
    input  logic [NCOMMIT-1:0]  div_ready,
    input  logic [NCOMMIT-1:0]  commit_kill,
    output logic                issue_valid,
    output logic [LNCOMMIT-1:0] issue_addr,
    output logic [NCOMMIT-1:0]  issue_ack,
    output logic                busy,
    output logic                done_valid,
    output logic [LNCOMMIT-1:0] done_addr
);

    localparam int CW = $clog2(DLAT + 1);

    div_state_t          r_state;
    logic [CW-1:0]       r_cnt;
    logic [LNCOMMIT-1:0] r_cur;
    logic                r_issue_valid;
    logic [LNCOMMIT-1:0] r_issue_addr;
    logic [NCOMMIT-1:0]  r_issue_ack;

    logic [NCOMMIT-1:0]  w_cand;
    logic                w_any;
    logic [LNCOMMIT-1:0] w_sel;
    logic                w_cur_killed;
    logic                w_launch;
    logic [NCOMMIT-1:0]  w_sel_onehot;

    assign w_cand = div_ready & ~commit_kill;

    oldest_pick #(
        .NCOMMIT  (NCOMMIT),
        .LNCOMMIT (LNCOMMIT)
    ) u_pick (
        .mask (w_cand),
        .head (commit_head),
        .any  (w_any),
        .idx  (w_sel)
    );

    assign w_cur_killed = commit_kill[r_cur];
    // DONE runs the same pick as IDLE so a new op can follow back-to-back.
    assign w_launch     = w_any && ((r_state == IDLE) || (r_state == DONE));
    assign w_sel_onehot = {{(NCOMMIT-1){1'b0}}, 1'b1} << w_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_cur         <= '0;
            r_issue_valid <= 1'b0;
            r_issue_addr  <= '0;
            r_issue_ack   <= '0;
        end else begin
            r_issue_valid <= w_launch;
            r_issue_ack   <= w_launch ? w_sel_onehot : '0;
            if (w_launch) begin
                r_issue_addr <= w_sel;
            end
            case (r_state)
                IDLE, DONE: begin
                    if (w_launch) begin
                        r_cur   <= w_sel;
                        r_cnt   <= CW'(DLAT - 1);
                        r_state <= BUSY;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    if (w_cur_killed) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) begin
                            r_state <= DONE;
                        end
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign issue_valid = r_issue_valid;
    assign issue_addr  = r_issue_addr;
    assign issue_ack   = r_issue_ack;
    assign busy        = (r_state == BUSY);
    assign done_valid  = (r_state == DONE) && !w_cur_killed;
    assign done_addr   = (r_state == DONE) ? r_cur : '0;

    a_ack_onehot: assert property (@(posedge clk) $onehot0(issue_ack));
    a_no_overlap: assert property (@(posedge clk) disable iff (reset)
                                   issue_valid |-> !$past(busy));
    a_dlat_min:   assert property (@(posedge clk) DLAT >= 2);

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Issue scheduler for the single shared, non-pipelined integer divide/remainder unit.
- Each cycle it selects the oldest divide-ready commit entry, measured from the commit head across the NCOMMIT circular window.
- It launches that entry on the unit, tracks the fixed unit latency, and reports completion back to the commit/writeback path.
- It sits beside the alu scheduler and only handles DIV/REM ops that the alu scheduler routes out.

Parameters:
- NCOMMIT, 32, number of commit entries; must be a power of two.
- LNCOMMIT, 5, log2(NCOMMIT).
- DLAT, 34, divide unit latency in cycles from issue to result; legal range 2..255.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- commit_head  in  LNCOMMIT  index of the oldest live commit entry.
- div_ready  in  NCOMMIT  bit i set: entry i holds a DIV/REM whose operands are ready.
- commit_kill  in  NCOMMIT  bit i set: entry i is flushed this cycle.
- issue_valid  out  1  one-cycle pulse: the unit starts the op in issue_addr.
- issue_addr  out  LNCOMMIT  commit entry being issued.
- issue_ack  out  NCOMMIT  one-hot copy of issue_addr, gated by issue_valid; clears the entry's ready bit upstream.
- busy  out  1  unit occupied (state BUSY).
- done_valid  out  1  one-cycle pulse: result for done_addr is available.
- done_addr  out  LNCOMMIT  entry completing.

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0, current entry 0.
- Candidate mask: cand = div_ready & ~commit_kill.
- Oldest-first pick:
  - rotate cand right by commit_head;
  - take the lowest set bit p;
  - sel = (p + commit_head) mod NCOMMIT, wrapping naturally in LNCOMMIT bits.
- issue_valid, issue_addr and issue_ack are registered: they are asserted in the cycle after the decision, which is the cycle the unit samples them.
- IDLE:
  - cand != 0: register sel, load cnt = DLAT-1, go to BUSY, pulse issue_valid next cycle.
  - cand == 0: stay in IDLE.
- BUSY:
  - decrement cnt each cycle.
  - cnt == 1 and cur not killed: go to DONE.
  - cur's bit set in commit_kill at any point in BUSY: go to IDLE next cycle, cnt cleared, no done_valid ever for that entry.
- DONE (one cycle):
  - done_valid = 1, done_addr = cur, both combinational from state.
  - Kill of cur in this same cycle: done_valid is suppressed.
  - The same decision logic as IDLE runs in this cycle, so a new op can issue back-to-back: its issue_valid appears the cycle after done_valid.
  - Next state: BUSY if a new op was selected, else IDLE.
- Net latency: issue_valid at cycle t gives done_valid at cycle t+DLAT-1 when the decision is made in IDLE.
- Ready bit still high in the cycle issue_ack is asserted: div_ready may show the just-selected entry; it is ignored because state is not IDLE/DONE.
- Head wrap: commit_head = NCOMMIT-1 with ready bits at 31 and 0 selects 31.
- Simultaneous kill of all candidates in IDLE: no issue.
- Reset asserted mid-BUSY:
  - next cycle is IDLE with all outputs 0;
  - the unit is expected to drop its internal state on the same reset;
  - no done_valid is produced.
- Assertions (sim only):
  - issue_ack is one-hot or zero;
  - issue_valid is never asserted while busy is already high from a previous issue;
  - DLAT >= 2.

Decomposition:
- Shared package rv_sched_pkg holds:
  - typedef commit_idx_t (logic [LNCOMMIT-1:0]);
  - enum div_state_t {IDLE, BUSY, DONE};
  - localparam CNTW = $clog2(DLAT+1).
- Sub-module oldest_pick (params NCOMMIT, LNCOMMIT): inputs mask and head; outputs any and idx. It is purely combinational (rotate plus priority encode) and reusable by the load/store schedulers.

Test Plan:
- Single issue: head=0, div_ready=0x10 for 1 cycle -> issue_valid at c+1 with addr 4, issue_ack=0x10; done_valid with addr 4 at c+1+33 (DLAT=34); busy high in between.
- Age order with wrap: head=30, div_ready bits {2,31,5} -> issue order 31, 2, 5, with ready maintained minus acked bits; each done is followed by the next issue on the cycle after done_valid.
- Kill mid-flight: issue entry 7; at cycle 10 of BUSY, commit_kill=0x80 -> state IDLE next cycle, no done_valid for 7; a pending entry 9 issues the following cycle.
- Same-cycle kill at selection: div_ready=0x3, commit_kill=0x1, head=0 -> entry 1 issued, entry 0 never issued.
- Reset mid-BUSY: reset pulse at cycle 5 after issue -> all outputs 0 next cycle, no done_valid through DLAT+5 cycles, then a fresh ready entry issues normally.
- Back-to-back stress: all 32 bits ready, head stepping by +1 after each done -> 32 issues in head order, exactly one done per issue, never two ops outstanding.
